// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider (DIV/DIVU), one quotient bit per cycle.
// Define DIV_ZERO_FAST_EN for a two-cycle divide-by-zero path through ZERO.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        annul,
  output logic        stall_req,
  output logic        busy,
  output logic        ready,
  output logic [63:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    ZERO,
    ON,
    END
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic [31:0] r_a;
  logic [4:0]  r_cnt;
  logic        r_negq;
  logic        r_negr;
  logic        r_busy;
  logic        r_ready;
  logic [63:0] r_result;

  logic        w_accept;
  logic        w_last;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_rem_n;
  logic [31:0] w_quo_n;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  assign w_accept = (r_state == IDLE)
                  & start & ~annul;
  assign w_last   = (r_cnt == 5'd31);

  // Partial remainder stays below the divisor, so 33 bits hold the shift.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_rem_n = w_ge ? (w_shift[31:0] - r_dvs)
                        : w_shift[31:0];
  assign w_quo_n = {r_quo[30:0], w_ge};

  assign w_abs_a = (signed_div & a[31]) ? (~a + 32'd1) : a;
  assign w_abs_b = (signed_div & b[31]) ? (~b + 32'd1) : b;
  assign w_q_fix = r_negq ? (~w_quo_n + 32'd1) : w_quo_n;
  assign w_r_fix = r_negr ? (~w_rem_n + 32'd1) : w_rem_n;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
`ifdef DIV_ZERO_FAST_EN
          w_next = (b == 32'd0) ? ZERO : ON;
`else
          w_next = ON;
`endif
        end
      end
      ZERO: w_next = annul ? IDLE : END;
      ON: begin
        if (annul)       w_next = IDLE;
        else if (w_last) w_next = END;
      end
      END:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign stall_req = ~rst & (w_accept
                   | (r_state == ZERO)
                   | (r_state == ON));
  assign busy      = r_busy;
  assign ready     = r_ready;
  assign result    = r_result;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= 64'h0;
      r_quo    <= 32'h0;
      r_rem    <= 32'h0;
      r_dvs    <= 32'h0;
      r_a      <= 32'h0;
      r_cnt    <= 5'd0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
    end else begin
      r_busy  <= (w_next != IDLE);
      r_ready <= (w_next == END);
      if (w_accept) begin
        r_a    <= a;
        r_quo  <= w_abs_a;
        r_rem  <= 32'h0;
        r_dvs  <= w_abs_b;
        r_negq <= signed_div & (a[31] ^ b[31]);
        r_negr <= signed_div & a[31];
        r_cnt  <= 5'd0;
      end else if (r_state == ON) begin
        r_quo <= w_quo_n;
        r_rem <= w_rem_n;
        r_cnt <= r_cnt + 5'd1;
        if (w_last && !annul)
          r_result <= {w_r_fix, w_q_fix};
      end
      if (r_state == ZERO && !annul)
        r_result <= {r_a, 32'hFFFF_FFFF};
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, results, annul, reset, start gating.
// Honours DIV_ZERO_FAST_EN for the divide-by-zero expectations.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic        stall_req;
  logic        busy;
  logic        ready;
  logic [63:0] result;

  int checks   = 0;
  int failures = 0;

  int          lat;
  int          nstall;
  int          npulse;
  int          nidle;
  logic [63:0] res;

  always #5 clk = ~clk;

  div_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .annul      (annul),
    .stall_req  (stall_req),
    .busy       (busy),
    .ready      (ready),
    .result     (result)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: the next rising edge accepts.
  task automatic issue(input logic [31:0] ia,
                       input logic [31:0] ib,
                       input logic        s);
    a          = ia;
    b          = ib;
    signed_div = s;
    start      = 1'b1;
    #1;
  endtask

  task automatic wait_ready(input  int          win,
                            input  bit          hold,
                            output int          o_lat,
                            output int          o_nstall,
                            output int          o_npulse,
                            output int          o_nidle,
                            output logic [63:0] o_res);
    o_lat    = -1;
    o_nstall = 0;
    o_npulse = 0;
    o_nidle  = 0;
    o_res    = 64'hx;
    for (int i = 1; i <= win; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      #1;
      if (stall_req) o_nstall++;
      if (!busy) o_nidle++;
      if (ready) begin
        o_npulse++;
        if (o_lat < 0) begin
          o_lat = i;
          o_res = result;
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    signed_div = 1'b0;
    a          = 32'h0;
    b          = 32'h0;
    annul      = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    start = 1'b1;
    #1;
    chk("rst_stall", 64'(stall_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_result", result, 64'h0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    #1;

    // unsigned 100 / 7
    issue(32'd100, 32'd7, 1'b0);
    chk("u_stall_n", 64'(stall_req), 64'd1);
    wait_ready(40, 1'b0, lat, nstall, npulse, nidle, res);
    chk("u_lat", 64'(lat), 64'd33);
    chk("u_pulses", 64'(npulse), 64'd1);
    chk("u_nstall", 64'(nstall), 64'd32);
    chk("u_res", res, {32'd2, 32'd14});
    chk("u_busy_end", 64'(busy), 64'd0);

    // signed -7 / 2
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_ready(40, 1'b0, lat, nstall, npulse, nidle, res);
    chk("s1_lat", 64'(lat), 64'd33);
    chk("s1_res", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // same bits unsigned
    issue(32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_ready(40, 1'b0, lat, nstall, npulse, nidle, res);
    chk("u2_res", res, {32'd1, 32'h7FFF_FFFC});

    // signed 7 / -2
    issue(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_ready(40, 1'b0, lat, nstall, npulse, nidle, res);
    chk("s2_res", res, {32'd1, 32'hFFFF_FFFD});

    // overflow case
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_ready(40, 1'b0, lat, nstall, npulse, nidle, res);
    chk("s3_res", res, {32'h0, 32'h8000_0000});

    // annul at N+10
    issue(32'd100, 32'd7, 1'b0);
    npulse = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start = 1'b0;
      annul = (i == 10);
      #1;
      if (ready) npulse++;
    end
    chk("an_busy", 64'(busy), 64'd0);
    chk("an_pulses", 64'(npulse), 64'd0);
    chk("an_result", result, {32'h0, 32'h8000_0000});
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_ready(40, 1'b0, lat, nstall, npulse, nidle, res);
    chk("an_new_lat", 64'(lat), 64'd33);
    chk("an_new_res", res, {32'h0, 32'hFFFF_FFFF});

    // reset at N+20
    issue(32'd100, 32'd7, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("mr_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_ready", 64'(ready), 64'd0);
    chk("mr_result", result, 64'h0);
    chk("mr_stall2", 64'(stall_req), 64'd0);
    issue(32'd9, 32'd3, 1'b0);
    wait_ready(40, 1'b0, lat, nstall, npulse, nidle, res);
    chk("mr_lat", 64'(lat), 64'd33);
    chk("mr_res", res, {32'd0, 32'd3});

    // divide by zero
    issue(32'd5, 32'd0, 1'b0);
    wait_ready(40, 1'b0, lat, nstall, npulse, nidle, res);
`ifdef DIV_ZERO_FAST_EN
    chk("dz_lat", 64'(lat), 64'd2);
    chk("dz_nstall", 64'(nstall), 64'd1);
    chk("dz_res", res, {32'd5, 32'hFFFF_FFFF});
`else
    chk("dz_lat", 64'(lat), 64'd33);
    chk("dz_nstall", 64'(nstall), 64'd32);
`endif
    chk("dz_pulses", 64'(npulse), 64'd1);

    // start held through an operation
    issue(32'd100, 32'd7, 1'b0);
    wait_ready(40, 1'b1, lat, nstall, npulse, nidle, res);
    chk("h_lat", 64'(lat), 64'd33);
    chk("h_pulses", 64'(npulse), 64'd1);
    chk("h_idle", 64'(nidle), 64'd1);
    chk("h_res", res, {32'd2, 32'd14});
    wait_ready(40, 1'b0, lat, nstall, npulse, nidle, res);
    chk("h2_lat", 64'(lat), 64'd27);
    chk("h2_pulses", 64'(npulse), 64'd1);

    // start with annul in IDLE
    @(negedge clk);
    start = 1'b1;
    annul = 1'b1;
    #1;
    chk("sa_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    start = 1'b0;
    annul = 1'b0;
    #1;
    chk("sa_busy", 64'(busy), 64'd0);
    chk("sa_ready", 64'(ready), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: start  input  1  request a division; sampled only in IDLE.
REQ-004 SHALL have port: signed_div  input  1  1 = DIV (signed), 0 = DIVU; latched with start.
REQ-005 SHALL have port: a  input  32  dividend; latched with start.
REQ-006 SHALL have port: b  input  32  divisor; latched with start.
REQ-007 SHALL have port: annul  input  1  pipeline flush (exception or eret); aborts the operation.
REQ-008 SHALL have port: stall_req  output  1  combinational stall request to the hazard unit.
REQ-009 SHALL have port: busy  output  1  registered; 1 in any state other than IDLE.
REQ-010 SHALL have port: ready  output  1  registered one-cycle completion pulse.
REQ-011 SHALL have port: result  output  64  {hi = remainder, lo = quotient}; valid when ready = 1, held until the next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, ZERO, ON, END.
REQ-013 SHALL accept start in IDLE when start = 1 and annul = 0; a start asserted together with annul SHALL be ignored.
REQ-014 SHALL latch a, b and signed_div on acceptance and ignore input changes until return to IDLE.
REQ-015 SHALL ignore start while busy = 1; no queueing.
REQ-016 On acceptance at cycle N (b != 0): ON for cycles N+1..N+32, one restoring shift-subtract step per cycle, END at N+33 with ready = 1, IDLE at N+34.
REQ-017 SHALL drive stall_req = (IDLE & start & ~annul) | ZERO | ON; stall_req = 0 in END, so the stalled instruction advances in the ready cycle.
REQ-018 Signed mode SHALL divide the absolute values.
  - Quotient negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
REQ-019 Arithmetic SHALL be 32-bit two's complement with wrap. 0x80000000 / 0xFFFFFFFF (signed) SHALL give quotient 0x80000000 and remainder 0.
REQ-020 annul = 1 in ZERO, ON or END SHALL force IDLE on the next edge.
  - ready is suppressed in that cycle.
  - result keeps its previous value.
  - busy = 0 on the following cycle.
REQ-021 ready SHALL be 1 only in END and for exactly one cycle per completed operation.

Reset
REQ-022 rst = 1 at a clock edge SHALL force IDLE from any state, including mid-division.
REQ-023 After that edge: busy = 0, ready = 0, result = 64'h0, internal iteration counter = 0.
REQ-024 stall_req SHALL be 0 while rst = 1.

Configuration
REQ-025 Macro DIV_ZERO_FAST_EN SHALL select divide-by-zero handling.
REQ-026 With DIV_ZERO_FAST_EN defined and latched b = 0:
  - Path is IDLE -> ZERO (cycle N+1) -> END (N+2, ready = 1) -> IDLE.
  - result = {a, 32'hFFFFFFFF}, regardless of signed_div.
REQ-027 Without DIV_ZERO_FAST_EN:
  - b = 0 takes the normal 32-cycle ON path.
  - ZERO is unreachable.
  - ready timing follows REQ-016; the result value is architecturally unpredictable (MIPS32) and is not checked.

Verification
REQ-028 Unsigned: a = 100, b = 7, start at cycle N -> ready at N+33 only, result = {32'd2, 32'd14}, stall_req high N..N+32.
REQ-029 Signed: a = 0xFFFFFFF9 (-7), b = 2 -> result = {32'hFFFFFFFF, 32'hFFFFFFFD}; then a = 0x80000000, b = 0xFFFFFFFF -> result = {32'h0, 32'h80000000}.
REQ-030 Annul: start, then annul at N+10 -> busy = 0 at N+12, no ready pulse, result unchanged; a new start at N+12 is accepted.
REQ-031 Reset mid-operation: rst at N+20 -> all outputs at reset values on the next cycle; a later start of 9/3 gives {32'd0, 32'd3}.
REQ-032 Divide by zero: a = 5, b = 0.
  - With DIV_ZERO_FAST_EN: ready at N+2, result = {32'd5, 32'hFFFFFFFF}.
  - Without it: ready at N+33.
REQ-033 Start ignore: start held high through a whole operation -> exactly one ready per accepted start, with IDLE lasting at least one cycle between operations; start together with annul in IDLE -> busy stays 0.
